// File: rtl/yolo_layer_pkg.sv
// Shared types and constant helpers for the YOLO layer sequencer.
package yolo_layer_pkg;

    // Layer pass sequencer states
    typedef enum logic [2:0] {
        IDLE,
        CLR,
        STREAM,
        DRAIN,
        NEXT,
        DONE
    } layer_state_t;

    // Number of input pixels in one square image
    function automatic int pix_count(input int img_size);
        return img_size * img_size;
    endfunction

    // Number of valid (unpadded) 3x3 window positions in one image
    function automatic int out_count(input int img_size);
        return (img_size - 2) * (img_size - 2);
    endfunction

endpackage

// File: rtl/raster_pos_counter.sv
// Column/row position counter over a square raster with a last-pixel flag.
module raster_pos_counter #(
    parameter int IMG_SIZE = 208,
    parameter int CW       = $clog2(IMG_SIZE)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          en,
    output logic [CW-1:0] col,
    output logic [CW-1:0] row,
    output logic          last
);

    localparam logic [CW-1:0] MAX_POS = CW'(IMG_SIZE - 1);

    logic [CW-1:0] col_reg;
    logic [CW-1:0] row_reg;

    // Advance column each enable; wrap to the next row at the image edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_reg <= '0;
            row_reg <= '0;
        end else if (clr) begin
            col_reg <= '0;
            row_reg <= '0;
        end else if (en) begin
            if (col_reg == MAX_POS) begin
                col_reg <= '0;
                row_reg <= (row_reg == MAX_POS) ? '0 : row_reg + 1'b1;
            end else begin
                col_reg <= col_reg + 1'b1;
            end
        end
    end

    assign col  = col_reg;
    assign row  = row_reg;
    assign last = (col_reg == MAX_POS) && (row_reg == MAX_POS);

endmodule

// File: rtl/layer_stream_sched.sv
// Sequencer for one convolution layer: streams the input image into the
// featuremap engines once per output featuremap and generates output-buffer
// writes for the valid 3x3 window positions.
module layer_stream_sched
    import yolo_layer_pkg::*;
#(
    parameter int IMG_SIZE   = 208,
    parameter int NUM_FM     = 16,
    parameter int ADDR_WIDTH = 16,
    parameter int FM_WIDTH   = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  stall,
    output logic                  rd_en,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    output logic                  conv_valid_in,
    output logic                  conv_clr,
    input  logic                  conv_valid_out,
    output logic [FM_WIDTH-1:0]   fm_idx,
    output logic                  wr_en,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    localparam int                    CW        = $clog2(IMG_SIZE);
    localparam logic [ADDR_WIDTH-1:0] LAST_PIX  = ADDR_WIDTH'(pix_count(IMG_SIZE) - 1);
    localparam logic [FM_WIDTH-1:0]   LAST_FM   = FM_WIDTH'(NUM_FM - 1);
    localparam logic [CW-1:0]         WIN_START = CW'(2);

    layer_state_t          state_reg;
    logic [ADDR_WIDTH-1:0] rd_addr_reg;
    logic [ADDR_WIDTH-1:0] wr_addr_reg;
    logic [FM_WIDTH-1:0]   fm_idx_reg;
    logic                  conv_valid_in_reg;
    logic                  err_reg;
    logic                  out_done_reg;

    logic [CW-1:0]         out_col;
    logic [CW-1:0]         out_row;
    logic                  out_last;

    logic                  issue;
    logic                  track_state;
    logic                  vo_accept;
    logic                  vo_bad;
    logic                  wr_fire;

    // Engine outputs are only meaningful while a featuremap is in flight and
    // before all of its outputs have been counted; anything else is an error.
    assign issue       = (state_reg == STREAM) && !stall;
    assign track_state = (state_reg == STREAM) || (state_reg == DRAIN);
    assign vo_accept   = conv_valid_out && track_state && !out_done_reg;
    assign vo_bad      = conv_valid_out && !vo_accept;
    assign wr_fire     = vo_accept && (out_col >= WIN_START) && (out_row >= WIN_START);

    raster_pos_counter #(
        .IMG_SIZE (IMG_SIZE),
        .CW       (CW)
    ) u_out_pos (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (state_reg == CLR),
        .en    (vo_accept),
        .col   (out_col),
        .row   (out_row),
        .last  (out_last)
    );

    // Pass sequencing, input address issue, output address and error tracking
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg         <= IDLE;
            rd_addr_reg       <= '0;
            wr_addr_reg       <= '0;
            fm_idx_reg        <= '0;
            conv_valid_in_reg <= 1'b0;
            err_reg           <= 1'b0;
            out_done_reg      <= 1'b0;
        end else begin
            // Input RAM has one cycle of read latency
            conv_valid_in_reg <= issue;

            if (wr_fire) begin
                wr_addr_reg <= wr_addr_reg + 1'b1;
            end
            if (vo_accept && out_last) begin
                out_done_reg <= 1'b1;
            end

            case (state_reg)
                IDLE: begin
                    if (start) begin
                        state_reg   <= CLR;
                        fm_idx_reg  <= '0;
                        rd_addr_reg <= '0;
                        wr_addr_reg <= '0;
                        err_reg     <= 1'b0;
                    end
                end
                CLR: begin
                    rd_addr_reg  <= '0;
                    wr_addr_reg  <= '0;
                    out_done_reg <= 1'b0;
                    state_reg    <= STREAM;
                end
                STREAM: begin
                    if (issue) begin
                        rd_addr_reg <= rd_addr_reg + 1'b1;
                        if (rd_addr_reg == LAST_PIX) begin
                            state_reg <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (out_done_reg || (vo_accept && out_last)) begin
                        state_reg <= NEXT;
                    end
                end
                NEXT: begin
                    if (fm_idx_reg == LAST_FM) begin
                        state_reg <= DONE;
                    end else begin
                        fm_idx_reg  <= fm_idx_reg + 1'b1;
                        rd_addr_reg <= '0;
                        wr_addr_reg <= '0;
                        state_reg   <= CLR;
                    end
                end
                DONE: begin
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase

            // A stray engine pulse is flagged even if start clears err this cycle
            if (vo_bad) begin
                err_reg <= 1'b1;
            end
        end
    end

    assign rd_en         = issue;
    assign rd_addr       = rd_addr_reg;
    assign conv_valid_in = conv_valid_in_reg;
    assign conv_clr      = (state_reg == CLR);
    assign fm_idx        = fm_idx_reg;
    assign wr_en         = wr_fire;
    assign wr_addr       = wr_addr_reg;
    assign busy          = (state_reg != IDLE);
    assign done          = (state_reg == DONE);
    assign err           = err_reg;

endmodule

// File: tb/tb_layer_stream_sched.sv
// Randomized self-checking bench for layer_stream_sched: a small instance
// (5x5, 2 featuremaps) with a delay-line engine model, and a full-size
// instance (208x208, 1 featuremap) with a zero-latency loopback.
module tb_layer_stream_sched;

    localparam int IMG  = 5;
    localparam int NF   = 2;
    localparam int PIX  = IMG * IMG;
    localparam int OUTN = (IMG - 2) * (IMG - 2);
    localparam int BIMG = 208;
    localparam int BPIX = BIMG * BIMG;
    localparam int BOUT = (BIMG - 2) * (BIMG - 2);

    logic clk;
    logic rst_n;

    // small instance signals
    logic       s_start, s_stall, s_rd_en, s_cvi, s_clr, s_vo, s_wr_en;
    logic       s_busy, s_done, s_err, s_inj;
    logic [7:0] s_rd_addr, s_wr_addr;
    logic [0:0] s_fm_idx;

    // big instance signals
    logic        b_start, b_stall, b_rd_en, b_cvi, b_clr, b_wr_en, b_busy, b_done, b_err;
    logic [15:0] b_rd_addr, b_wr_addr;
    logic [0:0]  b_fm_idx;

    int n_err = 0;
    int n_chk = 0;

    int stall_mode = 0;
    int eng_lat    = 3;
    logic [7:0] pipe;

    // small-instance scoreboard
    int clr_cnt, done_cnt, stall_viol, spur;
    int rd_n[4], rd_bad[4], vo_n[4], wr_exp[4], wr_obs[4], wr_bad[4], first_wr[4], fm_seen[4];

    // big-instance scoreboard
    int b_rd_n = 0, b_rd_bad = -1, b_wr_n = 0, b_wr_bad = -1, b_last = -1, b_done_n = 0;

    layer_stream_sched #(
        .IMG_SIZE(IMG), .NUM_FM(NF), .ADDR_WIDTH(8), .FM_WIDTH(1)
    ) u_small (
        .clk(clk), .rst_n(rst_n), .start(s_start), .stall(s_stall),
        .rd_en(s_rd_en), .rd_addr(s_rd_addr), .conv_valid_in(s_cvi),
        .conv_clr(s_clr), .conv_valid_out(s_vo), .fm_idx(s_fm_idx),
        .wr_en(s_wr_en), .wr_addr(s_wr_addr), .busy(s_busy), .done(s_done), .err(s_err)
    );

    layer_stream_sched #(
        .IMG_SIZE(BIMG), .NUM_FM(1), .ADDR_WIDTH(16), .FM_WIDTH(1)
    ) u_big (
        .clk(clk), .rst_n(rst_n), .start(b_start), .stall(b_stall),
        .rd_en(b_rd_en), .rd_addr(b_rd_addr), .conv_valid_in(b_cvi),
        .conv_clr(b_clr), .conv_valid_out(b_cvi), .fm_idx(b_fm_idx),
        .wr_en(b_wr_en), .wr_addr(b_wr_addr), .busy(b_busy), .done(b_done), .err(b_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Engine model: valid_out is valid_in delayed by eng_lat cycles
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) pipe <= '0;
        else        pipe <= {pipe[6:0], s_cvi};
    end
    assign s_vo = s_inj | pipe[eng_lat-1];

    // Stall generator
    initial begin
        s_stall = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (stall_mode)
                1:       s_stall = ~s_stall;
                2:       s_stall = ($urandom_range(0, 2) == 0);
                default: s_stall = 1'b0;
            endcase
        end
    end

    task automatic check_val(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d", tag, got, exp);
        end
    endtask

    task automatic mon_clear();
        clr_cnt = 0; done_cnt = 0; stall_viol = 0; spur = 0;
        for (int f = 0; f < 4; f++) begin
            rd_n[f] = 0; rd_bad[f] = -1; vo_n[f] = 0; wr_exp[f] = 0;
            wr_obs[f] = 0; wr_bad[f] = -1; first_wr[f] = -1; fm_seen[f] = -1;
        end
    endtask

    // Small-instance monitor: reference is raster arithmetic on the k-th engine output
    always @(negedge clk) begin
        int cur, k;
        bit expw;
        if (s_clr) begin
            if (clr_cnt < 4) fm_seen[clr_cnt] = int'(s_fm_idx);
            clr_cnt++;
        end
        if (clr_cnt > 0 && clr_cnt <= 4) begin
            cur = clr_cnt - 1;
            if (s_rd_en) begin
                if (int'(s_rd_addr) != rd_n[cur] && rd_bad[cur] < 0) rd_bad[cur] = rd_n[cur];
                rd_n[cur]++;
            end
            if (s_vo) begin
                k = vo_n[cur];
                expw = ((k % IMG) >= 2) && ((k / IMG) >= 2);
                if ((s_wr_en != expw || (expw && int'(s_wr_addr) != wr_exp[cur])) && wr_bad[cur] < 0)
                    wr_bad[cur] = k;
                if (s_wr_en && first_wr[cur] < 0) first_wr[cur] = k;
                if (expw) wr_exp[cur]++;
                if (s_wr_en) wr_obs[cur]++;
                vo_n[cur]++;
            end else if (s_wr_en) begin
                spur++;
            end
        end
        if (s_rd_en && s_stall) stall_viol++;
        if (s_done) done_cnt++;
    end

    // Big-instance monitor
    always @(negedge clk) begin
        if (b_rd_en) begin
            if (int'(b_rd_addr) != b_rd_n && b_rd_bad < 0) b_rd_bad = b_rd_n;
            b_rd_n++;
        end
        if (b_wr_en) begin
            if (int'(b_wr_addr) != b_wr_n && b_wr_bad < 0) b_wr_bad = b_wr_n;
            b_last = int'(b_wr_addr);
            b_wr_n++;
        end
        if (b_done) b_done_n++;
    end

    task automatic wait_done(input string tag, input int budget);
        int n = 0;
        while (done_cnt == 0 && n < budget) begin
            @(negedge clk);
            #1;
            n++;
        end
        check_val({tag, "_done_seen"}, int'(done_cnt > 0), 1);
    endtask

    task automatic check_pass(input string tag);
        check_val({tag, "_clr_pulses"}, clr_cnt, NF);
        check_val({tag, "_done_pulses"}, done_cnt, 1);
        check_val({tag, "_rd_under_stall"}, stall_viol, 0);
        check_val({tag, "_stray_wr"}, spur, 0);
        check_val({tag, "_err"}, int'(s_err), 0);
        for (int f = 0; f < NF; f++) begin
            check_val($sformatf("%s_fm%0d_idx", tag, f), fm_seen[f], f);
            check_val($sformatf("%s_fm%0d_reads", tag, f), rd_n[f], PIX);
            check_val($sformatf("%s_fm%0d_rd_seq", tag, f), rd_bad[f], -1);
            check_val($sformatf("%s_fm%0d_writes", tag, f), wr_obs[f], OUTN);
            check_val($sformatf("%s_fm%0d_wr_seq", tag, f), wr_bad[f], -1);
            check_val($sformatf("%s_fm%0d_first_wr", tag, f), first_wr[f], 2 * IMG + 2);
        end
        $display("pass %s: lat=%0d stall_mode=%0d reads=%0d/%0d writes=%0d/%0d",
                 tag, eng_lat, stall_mode, rd_n[0], rd_n[1], wr_obs[0], wr_obs[1]);
    endtask

    task automatic do_pass(input string tag, input int lat, input int smode, input bit extra_start);
        eng_lat = lat;
        stall_mode = smode;
        mon_clear();
        @(posedge clk); #1 s_start = 1'b1;
        @(posedge clk); #1 s_start = 1'b0;
        if (extra_start) begin
            repeat (15) @(posedge clk);
            #1 s_start = 1'b1;
            @(posedge clk); #1 s_start = 1'b0;
        end
        wait_done(tag, 2000);
        check_pass(tag);
        stall_mode = 0;
        repeat (2) @(negedge clk);
        #1;
    endtask

    initial begin
        int n;
        rst_n = 1'b0; s_start = 1'b0; s_inj = 1'b0; b_start = 1'b0; b_stall = 1'b0;
        mon_clear();
        #1;
        // reset state
        check_val("rst_busy", int'(s_busy), 0);
        check_val("rst_rd_en", int'(s_rd_en), 0);
        check_val("rst_clr", int'(s_clr), 0);
        check_val("rst_err", int'(s_err), 0);
        check_val("rst_rd_addr", int'(s_rd_addr), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk); #1;
        check_val("post_rst_done", int'(s_done), 0);

        // basic pass, then alternating stall
        do_pass("basic", 3, 0, 1'b0);
        do_pass("alt_stall", 3, 1, 1'b0);

        // start pulsed mid-pass is ignored
        do_pass("busy_start", 3, 0, 1'b1);

        // start held through DONE relaunches one cycle after IDLE
        eng_lat = 3;
        mon_clear();
        @(posedge clk); #1 s_start = 1'b1;
        wait_done("held1", 2000);
        check_pass("held1");
        @(negedge clk); #1;
        check_val("held_idle_busy", int'(s_busy), 0);
        mon_clear();
        @(negedge clk); #1;
        check_val("held_relaunch_clr", int'(s_clr), 1);
        s_start = 1'b0;
        wait_done("held2", 2000);
        check_pass("held2");
        repeat (2) @(negedge clk);

        // stray engine pulse in IDLE
        @(posedge clk); #1 s_inj = 1'b1;
        @(negedge clk); #1;
        check_val("idle_inj_wr_en", int'(s_wr_en), 0);
        @(posedge clk); #1 s_inj = 1'b0;
        @(negedge clk); #1;
        check_val("idle_inj_err", int'(s_err), 1);
        $display("inject: err=%0d", s_err);
        mon_clear();
        @(posedge clk); #1 s_start = 1'b1;
        @(posedge clk); #1 s_start = 1'b0;
        @(negedge clk); #1;
        check_val("start_clears_err", int'(s_err), 0);
        wait_done("after_err", 2000);
        check_pass("after_err");

        // randomized latency and stall passes
        for (int i = 0; i < 3; i++) begin
            do_pass($sformatf("rand%0d", i), int'($urandom_range(1, 7)), 2, 1'b0);
        end

        // async reset in the middle of streaming
        eng_lat = 3;
        mon_clear();
        @(posedge clk); #1 s_start = 1'b1;
        @(posedge clk); #1 s_start = 1'b0;
        n = 0;
        while (!(s_rd_en && int'(s_rd_addr) == 12) && n < 200) begin
            @(negedge clk); #1;
            n++;
        end
        check_val("midrst_reached_12", int'(s_rd_en && int'(s_rd_addr) == 12), 1);
        #1 rst_n = 1'b0;
        #1;
        check_val("midrst_rd_en", int'(s_rd_en), 0);
        check_val("midrst_rd_addr", int'(s_rd_addr), 0);
        check_val("midrst_cvi", int'(s_cvi), 0);
        check_val("midrst_busy", int'(s_busy), 0);
        check_val("midrst_wr_addr", int'(s_wr_addr), 0);
        check_val("midrst_fm_idx", int'(s_fm_idx), 0);
        check_val("midrst_done", int'(s_done), 0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk); #1;
        check_val("midrst_idle", int'(s_busy), 0);
        do_pass("after_rst", 3, 0, 1'b0);

        // full-size featuremap with zero-latency loopback
        @(posedge clk); #1 b_start = 1'b1;
        @(posedge clk); #1 b_start = 1'b0;
        n = 0;
        while (b_done_n == 0 && n < 50000) begin
            @(negedge clk); #1;
            n++;
        end
        check_val("big_done_seen", int'(b_done_n > 0), 1);
        check_val("big_reads", b_rd_n, BPIX);
        check_val("big_rd_seq", b_rd_bad, -1);
        check_val("big_writes", b_wr_n, BOUT);
        check_val("big_wr_seq", b_wr_bad, -1);
        check_val("big_last_wr_addr", b_last, BOUT - 1);
        check_val("big_err", int'(b_err), 0);
        $display("pass big: reads=%0d writes=%0d last_wr=%0d", b_rd_n, b_wr_n, b_last);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
